// File: rtl/mem_str_fwd_unit.sv
// mem_str_fwd_unit
//
// Store-data forwarding unit for the memory stage. Each store source
// register (top = upper part of the word, bot = lower byte) is resolved
// against the writeback slots of the current cycle and then against a
// DEPTH-entry history of past writeback pairs. The first valid candidate
// with a matching register supplies the data; otherwise the value latched
// at EX/MEM is used. The assembled store word is registered toward data
// memory together with a valid flag and per-part forward-hit flags.
//
// Ports:
//   clock              sole clock, rising-edge
//   reset              synchronous, active-high, dominant over stall
//   stall              freezes history and all output registers
//   wb_valid_top/bot   writeback slot valid this cycle
//   wb_reg_top/bot     writeback destination registers
//   wb_data_top/bot    writeback data
//   str_valid          store present in MEM this cycle
//   str_reg_top/bot    store source registers
//   str_data_top/bot   source values latched at EX/MEM
//   mem_data           registered store word
//   mem_data_valid     mem_data is valid for the memory write
//   fwd_hit            registered, [1] = top forwarded, [0] = bot forwarded
module mem_str_fwd_unit #(
  parameter int DATA_W   = 8,
  parameter int STR_W    = 12,
  parameter int RADDR_W  = 5,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               wb_valid_top,
  input  logic               wb_valid_bot,
  input  logic [RADDR_W-1:0] wb_reg_top,
  input  logic [RADDR_W-1:0] wb_reg_bot,
  input  logic [DATA_W-1:0]  wb_data_top,
  input  logic [DATA_W-1:0]  wb_data_bot,
  input  logic               str_valid,
  input  logic [RADDR_W-1:0] str_reg_top,
  input  logic [RADDR_W-1:0] str_reg_bot,
  input  logic [DATA_W-1:0]  str_data_top,
  input  logic [DATA_W-1:0]  str_data_bot,
  output logic [STR_W-1:0]   mem_data,
  output logic               mem_data_valid,
  output logic [1:0]         fwd_hit
);

  // Candidate list: current top, current bot, then top/bot of each
  // history entry from youngest to oldest. Lower index = higher priority.
  localparam int NCAND = 2*DEPTH + 2;

  logic [DEPTH-1:0]              r_histValidTop;
  logic [DEPTH-1:0]              r_histValidBot;
  logic [DEPTH-1:0][RADDR_W-1:0] r_histRegTop;
  logic [DEPTH-1:0][RADDR_W-1:0] r_histRegBot;
  logic [DEPTH-1:0][DATA_W-1:0]  r_histDataTop;
  logic [DEPTH-1:0][DATA_W-1:0]  r_histDataBot;

  logic [DEPTH-1:0]              w_nextValidTop;
  logic [DEPTH-1:0]              w_nextValidBot;
  logic [DEPTH-1:0][RADDR_W-1:0] w_nextRegTop;
  logic [DEPTH-1:0][RADDR_W-1:0] w_nextRegBot;
  logic [DEPTH-1:0][DATA_W-1:0]  w_nextDataTop;
  logic [DEPTH-1:0][DATA_W-1:0]  w_nextDataBot;

  logic [NCAND-1:0]              w_candValid;
  logic [NCAND-1:0][RADDR_W-1:0] w_candReg;
  logic [NCAND-1:0][DATA_W-1:0]  w_candData;

  // Index 1 = top source, index 0 = bot source, matching fwd_hit bits.
  logic [1:0][RADDR_W-1:0]       w_srcReg;
  logic [1:0][DATA_W-1:0]        w_srcData;
  logic [1:0]                    w_srcAllowed;
  logic [1:0][NCAND-1:0]         w_match;
  logic [1:0][NCAND:0]           w_hitAcc;
  logic [1:0][NCAND:0][DATA_W-1:0] w_valAcc;
  logic [1:0]                    w_resHit;
  logic [1:0][DATA_W-1:0]        w_resVal;
  logic [STR_W-1:0]              w_word;

  // Shift network: entry 0 takes the live writeback pair, entry k takes
  // entry k-1. The oldest entry simply falls off the end.
  for (genvar k = 0; k < DEPTH; k++) begin : gHistNext
    if (k == 0) begin : gHead
      assign w_nextValidTop[k] = wb_valid_top;
      assign w_nextValidBot[k] = wb_valid_bot;
      assign w_nextRegTop[k]   = wb_reg_top;
      assign w_nextRegBot[k]   = wb_reg_bot;
      assign w_nextDataTop[k]  = wb_data_top;
      assign w_nextDataBot[k]  = wb_data_bot;
    end else begin : gTail
      assign w_nextValidTop[k] = r_histValidTop[k-1];
      assign w_nextValidBot[k] = r_histValidBot[k-1];
      assign w_nextRegTop[k]   = r_histRegTop[k-1];
      assign w_nextRegBot[k]   = r_histRegBot[k-1];
      assign w_nextDataTop[k]  = r_histDataTop[k-1];
      assign w_nextDataBot[k]  = r_histDataBot[k-1];
    end
  end

  // Valid bits are the only history state that needs reset: an invalid
  // entry can never match, so reg/data contents are irrelevant. The
  // history shifts on every unstalled cycle, even with no writebacks,
  // so entry position always equals pipeline distance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_histValidTop <= '0;
      r_histValidBot <= '0;
    end else if (!stall) begin
      r_histValidTop <= w_nextValidTop;
      r_histValidBot <= w_nextValidBot;
    end
  end

  always_ff @(posedge clock) begin
    if (!stall) begin
      r_histRegTop  <= w_nextRegTop;
      r_histRegBot  <= w_nextRegBot;
      r_histDataTop <= w_nextDataTop;
      r_histDataBot <= w_nextDataBot;
    end
  end

  assign w_candValid[0] = wb_valid_top;
  assign w_candReg[0]   = wb_reg_top;
  assign w_candData[0]  = wb_data_top;
  assign w_candValid[1] = wb_valid_bot;
  assign w_candReg[1]   = wb_reg_bot;
  assign w_candData[1]  = wb_data_bot;

  for (genvar k = 0; k < DEPTH; k++) begin : gCand
    assign w_candValid[2+2*k] = r_histValidTop[k];
    assign w_candReg[2+2*k]   = r_histRegTop[k];
    assign w_candData[2+2*k]  = r_histDataTop[k];
    assign w_candValid[3+2*k] = r_histValidBot[k];
    assign w_candReg[3+2*k]   = r_histRegBot[k];
    assign w_candData[3+2*k]  = r_histDataBot[k];
  end

  assign w_srcReg[1]  = str_reg_top;
  assign w_srcReg[0]  = str_reg_bot;
  assign w_srcData[1] = str_data_top;
  assign w_srcData[0] = str_data_bot;

  // Priority chain built from the lowest-priority end: each stage either
  // takes its own candidate on a match or passes the younger result up,
  // so index 0 holds the highest-priority match (or the EX/MEM fallback).
  for (genvar s = 0; s < 2; s++) begin : gSrc
    assign w_srcAllowed[s]       = (ZERO_REG == 0) || (w_srcReg[s] != '0);
    assign w_hitAcc[s][NCAND]    = 1'b0;
    assign w_valAcc[s][NCAND]    = w_srcData[s];

    for (genvar c = 0; c < NCAND; c++) begin : gChain
      assign w_match[s][c]  = w_srcAllowed[s] && w_candValid[c] &&
                              (w_candReg[c] == w_srcReg[s]);
      assign w_hitAcc[s][c] = w_match[s][c] | w_hitAcc[s][c+1];
      assign w_valAcc[s][c] = w_match[s][c] ? w_candData[c] : w_valAcc[s][c+1];
    end

    assign w_resHit[s] = w_hitAcc[s][0];
    assign w_resVal[s] = w_valAcc[s][0];
  end

  // Only the low STR_W-DATA_W bits of the top value reach the word.
  assign w_word = {w_resVal[1][STR_W-DATA_W-1:0], w_resVal[0]};

  if (STR_W < 2*DATA_W) begin : gDropTop
    logic w_unusedTopBits;
    assign w_unusedTopBits = ^w_resVal[1][DATA_W-1:STR_W-DATA_W];
  end

  // Output register: the valid flag follows str_valid every unstalled
  // cycle, while the word and hit flags only update on a real store so
  // the last written word stays visible between stores.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_data       <= '0;
      mem_data_valid <= 1'b0;
      fwd_hit        <= 2'b00;
    end else if (!stall) begin
      mem_data_valid <= str_valid;
      if (str_valid) begin
        mem_data <= w_word;
        fwd_hit  <= w_resHit;
      end
    end
  end

endmodule

// File: tb/tb_mem_str_fwd_unit.sv
// tb_mem_str_fwd_unit
//
// Directed bench for mem_str_fwd_unit. Two instances share all inputs:
// dut uses ZERO_REG=1 (default), dutZ uses ZERO_REG=0. For every cycle
// the expected registered outputs of both are pushed to a scoreboard
// queue before the clock edge and popped/compared just after it.
module tb_mem_str_fwd_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        wb_valid_top, wb_valid_bot;
  logic [4:0]  wb_reg_top, wb_reg_bot;
  logic [7:0]  wb_data_top, wb_data_bot;
  logic        str_valid;
  logic [4:0]  str_reg_top, str_reg_bot;
  logic [7:0]  str_data_top, str_data_bot;

  logic [11:0] mem_data, mem_data_z;
  logic        mem_data_valid, mem_data_valid_z;
  logic [1:0]  fwd_hit, fwd_hit_z;

  always #5 clock = ~clock;

  mem_str_fwd_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .wb_valid_top(wb_valid_top), .wb_valid_bot(wb_valid_bot),
    .wb_reg_top(wb_reg_top), .wb_reg_bot(wb_reg_bot),
    .wb_data_top(wb_data_top), .wb_data_bot(wb_data_bot),
    .str_valid(str_valid),
    .str_reg_top(str_reg_top), .str_reg_bot(str_reg_bot),
    .str_data_top(str_data_top), .str_data_bot(str_data_bot),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .fwd_hit(fwd_hit)
  );

  mem_str_fwd_unit #(.ZERO_REG(0)) dutZ (
    .clock(clock), .reset(reset), .stall(stall),
    .wb_valid_top(wb_valid_top), .wb_valid_bot(wb_valid_bot),
    .wb_reg_top(wb_reg_top), .wb_reg_bot(wb_reg_bot),
    .wb_data_top(wb_data_top), .wb_data_bot(wb_data_bot),
    .str_valid(str_valid),
    .str_reg_top(str_reg_top), .str_reg_bot(str_reg_bot),
    .str_data_top(str_data_top), .str_data_bot(str_data_bot),
    .mem_data(mem_data_z), .mem_data_valid(mem_data_valid_z), .fwd_hit(fwd_hit_z)
  );

  typedef struct {
    logic        v;
    logic [11:0] d;
    logic [1:0]  h;
    logic [11:0] dz;
    logic [1:0]  hz;
  } expT;

  expT sbQ[$];
  int  checks   = 0;
  int  failures = 0;
  int  cycleNum = 0;

  // Single comparison point: every check in the bench funnels through here.
  task automatic checkVal(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cycleNum, obs, exp);
    end
  endtask

  // Pops the expectation pushed for this edge and compares both instances.
  task automatic checkOutput();
    expT e;
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard_empty cycle=%0d observed=0 expected=1", cycleNum);
    end else begin
      e = sbQ.pop_front();
      checkVal("valid",    {11'b0, mem_data_valid},   {11'b0, e.v});
      checkVal("data",     mem_data,                  e.d);
      checkVal("hit",      {10'b0, fwd_hit},          {10'b0, e.h});
      checkVal("valid_z0", {11'b0, mem_data_valid_z}, {11'b0, e.v});
      checkVal("data_z0",  mem_data_z,                e.dz);
      checkVal("hit_z0",   {10'b0, fwd_hit_z},        {10'b0, e.hz});
    end
  endtask

  // Pushes the expected post-edge outputs, clocks once, then checks.
  task automatic applyStimulus(input logic v, input logic [11:0] d, input logic [1:0] h,
                               input logic [11:0] dz, input logic [1:0] hz);
    expT e;
    e.v = v; e.d = d; e.h = h; e.dz = dz; e.hz = hz;
    sbQ.push_back(e);
    @(posedge clock);
    #1;
    cycleNum++;
    checkOutput();
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0;
    wb_valid_top = 1'b0; wb_reg_top = '0; wb_data_top = '0;
    wb_valid_bot = 1'b0; wb_reg_bot = '0; wb_data_bot = '0;
    str_valid = 1'b0;
    str_reg_top = '0; str_data_top = '0;
    str_reg_bot = '0; str_data_bot = '0;
  endtask

  task automatic wbTop(input logic [4:0] r, input logic [7:0] d);
    wb_valid_top = 1'b1; wb_reg_top = r; wb_data_top = d;
  endtask

  task automatic wbBot(input logic [4:0] r, input logic [7:0] d);
    wb_valid_bot = 1'b1; wb_reg_bot = r; wb_data_bot = d;
  endtask

  task automatic store(input logic [4:0] rt, input logic [7:0] dt,
                       input logic [4:0] rb, input logic [7:0] db);
    str_valid = 1'b1;
    str_reg_top = rt; str_data_top = dt;
    str_reg_bot = rb; str_data_bot = db;
  endtask

  initial begin
    // Reset held two cycles with a store present: outputs stay cleared.
    idle(); reset = 1'b1; store(5'd1, 8'h11, 5'd2, 8'h22);
    applyStimulus(1'b0, 12'h000, 2'b00, 12'h000, 2'b00);
    idle(); reset = 1'b1; store(5'd1, 8'h11, 5'd2, 8'h22);
    applyStimulus(1'b0, 12'h000, 2'b00, 12'h000, 2'b00);

    // Plain store, nothing to forward; top 8'h3C keeps only its low nibble.
    idle(); store(5'd1, 8'h3C, 5'd2, 8'hA5);
    applyStimulus(1'b1, 12'hCA5, 2'b00, 12'hCA5, 2'b00);

    // Current-slot forward to bot.
    idle(); wbBot(5'd3, 8'h11); store(5'd1, 8'h3C, 5'd3, 8'hFF);
    applyStimulus(1'b1, 12'hC11, 2'b01, 12'hC11, 2'b01);

    // Idle cycle: valid drops, word and hit hold.
    idle();
    applyStimulus(1'b0, 12'hC11, 2'b01, 12'hC11, 2'b01);

    // Aged forward: r7 written now, read from entry 0, entry 1, then gone.
    idle(); wbTop(5'd7, 8'h9E);
    applyStimulus(1'b0, 12'hC11, 2'b01, 12'hC11, 2'b01);
    idle(); store(5'd7, 8'h00, 5'd1, 8'h00);
    applyStimulus(1'b1, 12'hE00, 2'b10, 12'hE00, 2'b10);
    idle(); store(5'd7, 8'h00, 5'd1, 8'h00);
    applyStimulus(1'b1, 12'hE00, 2'b10, 12'hE00, 2'b10);
    idle(); store(5'd7, 8'h00, 5'd1, 8'h00);
    applyStimulus(1'b1, 12'h000, 2'b00, 12'h000, 2'b00);

    // Current bot slot beats an older r4 sitting in entry 1.
    idle(); wbBot(5'd4, 8'h22);
    applyStimulus(1'b0, 12'h000, 2'b00, 12'h000, 2'b00);
    idle();
    applyStimulus(1'b0, 12'h000, 2'b00, 12'h000, 2'b00);
    idle(); wbBot(5'd4, 8'h33); store(5'd1, 8'h00, 5'd4, 8'h00);
    applyStimulus(1'b1, 12'h033, 2'b01, 12'h033, 2'b01);

    // Entry 0 (bot, 8'hBB) beats entry 1 (top, 8'hAA) for both sources.
    idle(); wbTop(5'd5, 8'hAA);
    applyStimulus(1'b0, 12'h033, 2'b01, 12'h033, 2'b01);
    idle(); wbBot(5'd5, 8'hBB);
    applyStimulus(1'b0, 12'h033, 2'b01, 12'h033, 2'b01);
    idle(); store(5'd5, 8'h00, 5'd5, 8'h00);
    applyStimulus(1'b1, 12'hBBB, 2'b11, 12'hBBB, 2'b11);

    // Both current slots write r4: top slot wins.
    idle(); wbTop(5'd4, 8'h44); wbBot(5'd4, 8'h55); store(5'd4, 8'h00, 5'd4, 8'h00);
    applyStimulus(1'b1, 12'h444, 2'b11, 12'h444, 2'b11);

    // Register 0: ignored with ZERO_REG=1, forwarded with ZERO_REG=0.
    idle(); wbBot(5'd0, 8'h77);
    applyStimulus(1'b0, 12'h444, 2'b11, 12'h444, 2'b11);
    idle(); store(5'd1, 8'h00, 5'd0, 8'h00);
    applyStimulus(1'b1, 12'h000, 2'b00, 12'h077, 2'b01);

    // Stall: r2=66 enters history, then five stalled cycles present r2=99.
    idle(); wbTop(5'd2, 8'h66); store(5'd1, 8'h03, 5'd1, 8'h5A);
    applyStimulus(1'b1, 12'h35A, 2'b00, 12'h35A, 2'b00);
    for (int i = 0; i < 5; i++) begin
      idle(); stall = 1'b1;
      wbTop(5'd2, 8'h99); wbBot(5'd2, 8'h99); store(5'd2, 8'hEE, 5'd2, 8'hEE);
      applyStimulus(1'b1, 12'h35A, 2'b00, 12'h35A, 2'b00);
    end
    idle(); store(5'd9, 8'h00, 5'd2, 8'h00);
    applyStimulus(1'b1, 12'h066, 2'b01, 12'h066, 2'b01);
    idle(); store(5'd9, 8'h00, 5'd2, 8'h00);
    applyStimulus(1'b1, 12'h066, 2'b01, 12'h066, 2'b01);
    idle(); wbTop(5'd6, 8'hFE); store(5'd9, 8'h00, 5'd2, 8'h00);
    applyStimulus(1'b1, 12'h000, 2'b00, 12'h000, 2'b00);

    // Reset mid-store clears outputs and history (r6 must not forward).
    idle(); reset = 1'b1; store(5'd1, 8'h11, 5'd1, 8'h22);
    applyStimulus(1'b0, 12'h000, 2'b00, 12'h000, 2'b00);
    idle(); store(5'd1, 8'h05, 5'd6, 8'h34);
    applyStimulus(1'b1, 12'h534, 2'b00, 12'h534, 2'b00);
    idle();
    applyStimulus(1'b0, 12'h534, 2'b00, 12'h534, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
